// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM receive-side tag check.
package gcm_pkg;

    localparam int unsigned GCM_BLK_W     = 128;
    localparam int unsigned GCM_TAG_BYTES = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2,
        S_RELEASE = 2'd3
    } gcm_state_e;

    // Mask keeping the most-significant nbytes bytes; unsupported lengths fall back to all 16.
    function automatic logic [GCM_BLK_W-1:0] tag_mask(input logic [4:0] nbytes);
        logic [4:0]           n;
        logic [GCM_BLK_W-1:0] m;
        n = nbytes;
        if (!(n == 5'd4 || n == 5'd8 || (n >= 5'd12 && n <= 5'd16)))
            n = 5'd16;
        m = '0;
        for (int unsigned i = 0; i < GCM_TAG_BYTES; i++) begin
            if (5'(i) < n)
                m[GCM_BLK_W-1-8*i -: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_pt_buffer.sv
// Circular plaintext buffer of DEPTH 128-bit blocks with occupancy count.
module gcm_pt_buffer
    import gcm_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_wr,
    input  logic [GCM_BLK_W-1:0]      i_wdata,
    input  logic                      i_rd,
    output logic [GCM_BLK_W-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [GCM_BLK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_we;
    logic                 w_re;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_we    = i_wr && !o_full && !i_clr;
    assign w_re    = i_rd && (r_count != '0) && !i_clr;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is intentionally not reset; only the pointers and count are.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_re)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_we) - CNT_W'(w_re);
        end
    end

endmodule

// File: rtl/gcm_tag_check.sv
// Authentication gate: buffers decrypted plaintext and releases it only if the tag matches.
// Optional macro GCM_TAG_TRUNC_EN adds tag_bytes_i for truncated-tag comparison.
module gcm_tag_check
    import gcm_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [GCM_BLK_W-1:0]  exp_tag_i,
    input  logic                  exp_tag_valid_i,
`ifdef GCM_TAG_TRUNC_EN
    input  logic [4:0]            tag_bytes_i,
`endif
    input  logic [GCM_BLK_W-1:0]  din_i,
    input  logic                  din_valid_i,
    input  logic [GCM_BLK_W-1:0]  tag_i,
    input  logic                  tag_valid_i,
    output logic [GCM_BLK_W-1:0]  dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
    output logic                  dout_last_o,
    output logic                  auth_ok_o,
    output logic                  auth_fail_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    gcm_state_e           r_state;
    gcm_state_e           w_state_nxt;
    logic [GCM_BLK_W-1:0] r_tag;
    logic [GCM_BLK_W-1:0] r_exp_tag;
    logic                 r_exp_seen;
    logic                 r_ovf;
    logic                 r_auth_ok;
    logic                 r_auth_fail;
    logic [GCM_BLK_W-1:0] w_exp_tag_eff;
    logic [GCM_BLK_W-1:0] w_mask;
    logic                 w_exp_now;
    logic                 w_match;
    logic                 w_clr;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ok_nxt;
    logic                 w_fail_nxt;
    logic                 w_full;
    logic [CNT_W-1:0]     w_count;
    logic [GCM_BLK_W-1:0] w_rdata;

    gcm_pt_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_wr    (w_wr),
        .i_wdata (din_i),
        .i_rd    (w_rd),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // An expected tag arriving in the compare cycle is used immediately.
    assign w_exp_now     = r_exp_seen || exp_tag_valid_i;
    assign w_exp_tag_eff = exp_tag_valid_i ? exp_tag_i : r_exp_tag;

`ifdef GCM_TAG_TRUNC_EN
    logic [4:0] r_tag_bytes;
    logic [4:0] w_bytes_eff;

    assign w_bytes_eff = exp_tag_valid_i ? tag_bytes_i : r_tag_bytes;
    assign w_mask      = tag_mask(w_bytes_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tag_bytes <= 5'(GCM_TAG_BYTES);
        else if (r_state != S_IDLE && exp_tag_valid_i)
            r_tag_bytes <= tag_bytes_i;
    end
`else
    assign w_mask = '1;
`endif

    // Constant-time compare: full-width XOR then OR-reduce.
    assign w_match = !r_ovf && !(|((r_tag ^ w_exp_tag_eff) & w_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_ok_nxt    = 1'b0;
        w_fail_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_wr = din_valid_i;
                if (tag_valid_i)
                    w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_exp_now) begin
                    if (w_match) begin
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = (w_count != '0) ? S_RELEASE : S_IDLE;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RELEASE: begin
                w_rd = dout_ready_i;
                if (dout_ready_i && w_count == CNT_W'(1))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-message flags, captured tags and the registered verdict pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag       <= '0;
            r_exp_tag   <= '0;
            r_exp_seen  <= 1'b0;
            r_ovf       <= 1'b0;
            r_auth_ok   <= 1'b0;
            r_auth_fail <= 1'b0;
        end else begin
            r_auth_ok   <= w_ok_nxt;
            r_auth_fail <= w_fail_nxt;
            if (r_state == S_IDLE) begin
                if (start_i) begin
                    r_exp_seen <= 1'b0;
                    r_ovf      <= 1'b0;
                end
            end else if (exp_tag_valid_i) begin
                r_exp_tag  <= exp_tag_i;
                r_exp_seen <= 1'b1;
            end
            if (r_state == S_COLLECT) begin
                if (din_valid_i && w_full)
                    r_ovf <= 1'b1;
                if (tag_valid_i)
                    r_tag <= tag_i;
            end
        end
    end

    assign dout_valid_o = (r_state == S_RELEASE);
    assign dout_o       = dout_valid_o ? w_rdata : '0;
    assign dout_last_o  = dout_valid_o && (w_count == CNT_W'(1));
    assign auth_ok_o    = r_auth_ok;
    assign auth_fail_o  = r_auth_fail;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_gcm_tag_check.sv
// Randomized and directed checks of gcm_tag_check against a message-level reference model.
module tb_gcm_tag_check;

    localparam int unsigned TB_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [127:0] exp_tag_i;
    logic         exp_tag_valid_i;
    logic [4:0]   tag_bytes_i;
    logic [127:0] din_i;
    logic         din_valid_i;
    logic [127:0] tag_i;
    logic         tag_valid_i;
    logic [127:0] dout_o;
    logic         dout_valid_o;
    logic         dout_ready_i;
    logic         dout_last_o;
    logic         auth_ok_o;
    logic         auth_fail_o;
    logic         busy_o;

    int n_vec = 0;
    int n_bad = 0;
    logic [127:0] q_in [$];

    gcm_tag_check #(.DEPTH(TB_DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .exp_tag_i       (exp_tag_i),
        .exp_tag_valid_i (exp_tag_valid_i),
`ifdef GCM_TAG_TRUNC_EN
        .tag_bytes_i     (tag_bytes_i),
`endif
        .din_i           (din_i),
        .din_valid_i     (din_valid_i),
        .tag_i           (tag_i),
        .tag_valid_i     (tag_valid_i),
        .dout_o          (dout_o),
        .dout_valid_o    (dout_valid_o),
        .dout_ready_i    (dout_ready_i),
        .dout_last_o     (dout_last_o),
        .auth_ok_o       (auth_ok_o),
        .auth_fail_o     (auth_fail_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: bytes compared counted from the MSB; unsupported lengths mean all 16.
    function automatic logic [127:0] model_mask(input logic [4:0] nb);
        logic [127:0] m;
        int           n;
        m = '1;
`ifdef GCM_TAG_TRUNC_EN
        n = int'(nb);
        if (!(n == 4 || n == 8 || (n >= 12 && n <= 16)))
            n = 16;
        m = m << (8 * (16 - n));
`else
        n = int'(nb);
        if (n < 0) m = '0;
`endif
        return m;
    endfunction

    task automatic fill_rand(input int n);
        q_in.delete();
        for (int i = 0; i < n; i++)
            q_in.push_back(rnd128());
    endtask

    // One message: late<0 means expected tag sent during collect (with a decoy first);
    // late>=0 means it arrives that many cycles after entering compare.
    task automatic run_msg(input logic [127:0] tg, input logic [127:0] et, input logic [4:0] nb,
                           input int late, input int rmode, input bit comb, input int rst_at);
        int  n;
        int  nacc;
        bit  pass;
        int  idx;
        int  guard;
        bit  rdy;
        bit  aborted;
        n       = q_in.size();
        nacc    = (n > int'(TB_DEPTH)) ? int'(TB_DEPTH) : n;
        pass    = (n <= int'(TB_DEPTH)) && (((tg ^ et) & model_mask(nb)) == '0);
        aborted = 1'b0;
        tag_bytes_i = nb;

        // A stray block while idle must not enter the buffer.
        @(negedge clk);
        chk("idle_busy", 128'(busy_o), 128'(0));
        din_valid_i = 1'b1; din_i = rnd128();
        @(negedge clk);
        din_valid_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("collect_busy", 128'(busy_o), 128'(1));
        if (late < 0) begin
            exp_tag_valid_i = 1'b1; exp_tag_i = ~et;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_tag_valid_i = 1'b0;
            din_valid_i = 1'b1; din_i = q_in[i];
            if (comb && i == n - 1) begin
                tag_valid_i = 1'b1; tag_i = tg;
                if (late < 0) begin exp_tag_valid_i = 1'b1; exp_tag_i = et; end
            end
        end
        if (!(comb && n > 0)) begin
            @(negedge clk);
            din_valid_i = 1'b0; exp_tag_valid_i = 1'b0;
            tag_valid_i = 1'b1; tag_i = tg;
            if (late < 0) begin exp_tag_valid_i = 1'b1; exp_tag_i = et; end
        end
        @(negedge clk);
        din_valid_i = 1'b0; tag_valid_i = 1'b0; exp_tag_valid_i = 1'b0;
        if (late >= 0) begin
            for (int k = 0; k < late; k++) begin
                chk("hold_ok", 128'(auth_ok_o | auth_fail_o | dout_valid_o), 128'(0));
                chk("hold_busy", 128'(busy_o), 128'(1));
                @(negedge clk);
            end
            exp_tag_valid_i = 1'b1; exp_tag_i = et;
        end
        chk("pre_verdict", 128'(auth_ok_o | auth_fail_o), 128'(0));
        @(negedge clk);
        exp_tag_valid_i = 1'b0;
        chk("auth_ok", 128'(auth_ok_o), 128'(pass));
        chk("auth_fail", 128'(auth_fail_o), 128'(!pass));
        chk("first_valid", 128'(dout_valid_o), 128'(pass && nacc > 0));
        chk("verdict_busy", 128'(busy_o), 128'(pass && nacc > 0));

        if (pass && nacc > 0) begin
            idx = 0; guard = 0;
            while (idx < nacc && guard < 200 && !aborted) begin
                if (rst_at >= 0 && idx == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_outs", 128'({dout_valid_o, dout_last_o, auth_ok_o, auth_fail_o, busy_o}), 128'(0));
                    chk("rst_dout", dout_o, 128'(0));
                    @(negedge clk);
                    rst_n = 1'b1;
                    aborted = 1'b1;
                end else begin
                    chk("rel_valid", 128'(dout_valid_o), 128'(1));
                    chk("rel_data", dout_o, q_in[idx]);
                    chk("rel_last", 128'(dout_last_o), 128'(idx == nacc - 1));
                    case (rmode)
                        0:       rdy = 1'b1;
                        1:       rdy = (guard % 2 == 0);
                        default: rdy = 1'($urandom_range(0, 1));
                    endcase
                    dout_ready_i = rdy;
                    @(negedge clk);
                    if (rdy) idx++;
                    guard++;
                end
            end
            if (!aborted && idx < nacc)
                chk("rel_timeout", 128'(idx), 128'(nacc));
        end else begin
            @(negedge clk);
        end
        dout_ready_i = 1'b1;
        chk("end_valid", 128'(dout_valid_o), 128'(0));
        chk("end_dout", dout_o, 128'(0));
        chk("end_busy", 128'(busy_o), 128'(0));
        chk("end_pulse", 128'(auth_ok_o | auth_fail_o), 128'(0));
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] a4;
        logic [127:0] tg;
        logic [127:0] et;
        rst_n = 1'b0; start_i = 1'b0; exp_tag_i = '0; exp_tag_valid_i = 1'b0;
        tag_bytes_i = 5'd16; din_i = '0; din_valid_i = 1'b0; tag_i = '0;
        tag_valid_i = 1'b0; dout_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", 128'({dout_valid_o, dout_last_o, auth_ok_o, auth_fail_o, busy_o}), 128'(0));
        chk("reset_dout", dout_o, 128'(0));
        rst_n = 1'b1;

        a5 = {16{8'hA5}};
        a4 = {{15{8'hA5}}, 8'hA4};

        // Basic match: three blocks released in order.
        q_in.delete();
        q_in.push_back({16{8'h11}}); q_in.push_back({16{8'h22}}); q_in.push_back({16{8'h33}});
        run_msg(a5, a5, 5'd16, -1, 0, 1'b0, -1);
        // Mismatch in the last bit: nothing released.
        run_msg(a5, a4, 5'd16, -1, 0, 1'b0, -1);
        // Overflow: one block more than the buffer holds.
        fill_rand(5);
        run_msg(a5, a5, 5'd16, 0, 0, 1'b0, -1);
        // Late expected tag with a toggling consumer.
        fill_rand(3);
        run_msg(a5, a5, 5'd16, 10, 1, 1'b1, -1);
        // Reset in the middle of release, then a zero-length message.
        fill_rand(4);
        run_msg(a5, a5, 5'd16, 0, 0, 1'b0, 2);
        q_in.delete();
        run_msg(a5, a5, 5'd16, -1, 0, 1'b0, -1);
        // Full buffer exactly at capacity.
        fill_rand(4);
        run_msg(a5, a5, 5'd16, 1, 2, 1'b1, -1);

`ifdef GCM_TAG_TRUNC_EN
        tg = rnd128();
        et = tg ^ 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
        fill_rand(2);
        run_msg(tg, et, 5'd12, -1, 0, 1'b0, -1);
        run_msg(tg, et, 5'd7, 0, 0, 1'b0, -1);
        run_msg(tg, et, 5'd16, 2, 0, 1'b0, -1);
`endif

        for (int r = 0; r < 24; r++) begin
            fill_rand(int'($urandom_range(0, 6)));
            tg = rnd128();
            et = ($urandom_range(0, 1) == 1) ? tg : (tg ^ (128'(1) << $urandom_range(0, 127)));
            run_msg(tg, et, 5'd16, int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gcm_tag_check.md
# gcm_tag_check

Receive-side authentication gate that sits directly downstream of `aes_gcm` in decrypt mode. It captures every plaintext block from `dout_o`/`dout_valid_o` into an internal buffer and captures the computed tag from `tag_o`/`tag_valid_o`. It compares that tag with the expected tag carried in the received frame. Plaintext is released to the consumer only on a match; on a mismatch it is discarded, so unauthenticated data never leaves the crypto subsystem.

## Interface
- `DEPTH`, 16: plaintext buffer capacity in 128-bit blocks; power of two, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  begin new message; honoured only in S_IDLE.
- `exp_tag_i`  in  128  expected (received) tag.
- `exp_tag_valid_i`  in  1  latches `exp_tag_i`; accepted in any state except S_IDLE.
- `din_i`  in  128  plaintext block from `aes_gcm` `dout_o`.
- `din_valid_i`  in  1  from `aes_gcm` `dout_valid_o`. There is no backpressure: a block is accepted whenever this is high.
- `tag_i`  in  128  computed tag from `aes_gcm` `tag_o`.
- `tag_valid_i`  in  1  from `aes_gcm` `tag_valid_o`; single-cycle pulse.
- `dout_o`  out  128  released plaintext; 0 whenever `dout_valid_o`=0.
- `dout_valid_o`  out  1  released block valid.
- `dout_ready_i`  in  1  consumer ready.
- `dout_last_o`  out  1  qualifies the final released block.
- `auth_ok_o`  out  1  one-cycle pulse: tag matched.
- `auth_fail_o`  out  1  one-cycle pulse: mismatch or overflow.
- `busy_o`  out  1  high in every state except S_IDLE.

## Operation
- **S_IDLE**
  - On `start_i`: clear `wr_ptr`, `rd_ptr`, `count`, `exp_seen`, `ovf`; go to S_COLLECT.
  - `din_valid_i` and `tag_valid_i` are ignored here.
- **S_COLLECT**
  - Each `din_valid_i` writes `mem[wr_ptr]`, increments `wr_ptr` (wraps mod DEPTH) and increments `count`.
  - If `din_valid_i` arrives with `count`==DEPTH, the block is dropped and `ovf` is set sticky.
  - On `tag_valid_i`: register `tag_i`, then go to S_COMPARE. If `din_valid_i` is high in the same cycle, that block is still written.
- **S_COMPARE**
  - Stays here until `exp_seen`=1. An `exp_tag_valid_i` in this state is used in the same cycle.
  - Match condition: `ovf`=0 and the tags compare equal. The comparison is a full-width XOR-OR reduction with no early exit.
  - On match: if `count`>0, go to S_RELEASE; if `count`==0, go to S_IDLE.
  - On mismatch: go to S_IDLE and reset `count`/pointers; the buffered data is discarded.
- **S_RELEASE**
  - `dout_valid_o`=1 and `dout_o`=`mem[rd_ptr]`. Each handshake increments `rd_ptr` and decrements `count`.
  - `dout_last_o`=1 when `count`==1.
  - When the last block handshakes, go to S_IDLE.
- **Expected tag timing:** `exp_tag_valid_i` may arrive at any point in S_COLLECT or S_COMPARE; the last value received wins.
- **Pointer widths:** pointers are $clog2(DEPTH) bits; `count` is $clog2(DEPTH)+1 bits.

## Timing
- **Reset values:** every output is 0; state is S_IDLE; pointers, `count` and flags are 0. Buffer memory is not reset.
- **Reset mid-operation:** all buffered data is abandoned immediately and no pulse is emitted.
- **Decision latency:**
  - `tag_valid_i` in cycle T puts the block in S_COMPARE at T+1 (given `exp_seen`).
  - The decision is made at T+1.
  - `auth_ok_o`/`auth_fail_o` are registered and pulse at T+2.
  - First `dout_valid_o` is at T+2, the same cycle as `auth_ok_o`.
- **Release throughput:** one block per cycle while `dout_ready_i`=1.
- **Consumer rules:** the consumer may stall indefinitely. `dout_o` must stay stable while `dout_valid_o`=1 and `dout_ready_i`=0.
- **Back-to-back messages:** `start_i` is accepted no earlier than the cycle after the block returns to S_IDLE.

## Configuration
- **Without `GCM_TAG_TRUNC_EN`:** the full 128-bit tag is always compared.
- **With `GCM_TAG_TRUNC_EN`:**
  - An extra port `tag_bytes_i` (in, 5 bits) is added and sampled with `exp_tag_valid_i`.
  - Only the most-significant `tag_bytes_i` bytes are compared.
  - Legal values are 4, 8 and 12–16. Any other value compares all 16 bytes.

## Structure
- **Shared package `gcm_pkg`:** holds the state enum (S_IDLE, S_COLLECT, S_COMPARE, S_RELEASE) and the constant `GCM_BLK_W`=128, alongside the existing `define.svh` constants.
- **Sub-module `gcm_pt_buffer`:** a DEPTH×128 circular buffer with write, read, count and full signals. The FSM and tag comparison live in the top module.

## Test plan
- **Match:** `start_i`, 3 blocks 0x11…, 0x22…, 0x33…, `exp_tag`=`tag`=0xA5A5… → `auth_ok_o` pulse at T+2. The three blocks are released in order, with `dout_last_o` on 0x33….
- **Mismatch:** 3 blocks, `tag`=0xA5…A5, `exp_tag`=0xA5…A4 → `auth_fail_o` pulse, no `dout_valid_o` at all, returns to S_IDLE.
- **Overflow:** DEPTH=4, 5 blocks, matching tags → `auth_fail_o` and no release.
- **Late expected tag with stalls:** `exp_tag_valid_i` arrives 10 cycles after `tag_valid_i` → block holds in S_COMPARE, then `auth_ok_o`. With `dout_ready_i` toggling 1/0, data stays stable and the count is correct.
- **Reset and zero-length:** `rst_n` pulsed mid-S_RELEASE → all outputs 0, next message works. A zero-block message with matching tags → `auth_ok_o` only.
- **Truncated tag (`GCM_TAG_TRUNC_EN`):** `tag_bytes_i`=12, tags differing only in the low 4 bytes → `auth_ok_o`. `tag_bytes_i`=7 with the same tags → `auth_fail_o`.
